// File: rtl/dmem_req_issuer_if.sv
// dmem_req_issuer_if: SRAM-like data bus between the request issuer
// (master) and the data memory port (slave).
interface dmem_req_issuer_if;
  logic        o_req;
  logic        o_wr;
  logic [1:0]  o_size;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;

  modport master (
    output o_req, o_wr, o_size,
    output o_addr, o_wdata, o_wstrb,
    input  i_addr_ok, i_data_ok, i_rdata
  );

  modport slave (
    input  o_req, o_wr, o_size,
    input  o_addr, o_wdata, o_wstrb,
    output i_addr_ok, i_data_ok, i_rdata
  );
endinterface

// File: rtl/dmem_req_issuer.sv
// dmem_req_issuer: drains the data-request FIFO onto an SRAM-like bus
// and returns load data one cycle after the read response.
module dmem_req_issuer #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_datareq_valid,
  input  logic [31:0]       i_va,
  input  logic [31:0]       i_data,
  input  logic [3:0]        i_byteen,
  input  logic              i_ren,
  input  logic              i_wen,
  output logic              o_read_stall,
  output logic              o_write_stall,
  dmem_req_issuer_if.master bus,
  output logic              o_rdata_valid,
  output logic [31:0]       o_rdata,
  output logic              o_idle
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LASTP = PW'(MAX_OUTSTANDING - 1);

  typedef struct packed {
    logic [31:0] va;
    logic [31:0] data;
    logic [3:0]  be;
    logic        wr;
  } hold_t;

  logic                       hold_v_q, hold_v_d;
  hold_t                      hold_q, hold_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] kind_q, kind_d;
  logic [PW-1:0]              wptr_q, wptr_d;
  logic [PW-1:0]              rptr_q, rptr_d;
  logic                       rdv_q, rdv_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       issue, resp;
  logic                       can_acc, pop;

  function automatic logic [1:0] be2size(input logic [3:0] be);
    case (be)
      4'b0011, 4'b1100: return 2'd1;
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: return 2'd0;
      default:          return 2'd2;
    endcase
  endfunction

  assign bus.o_req   = hold_v_q && (cnt_q < MAXC);
  assign bus.o_wr    = hold_q.wr;
  assign bus.o_size  = be2size(hold_q.be);
  assign bus.o_addr  = hold_q.va;
  assign bus.o_wdata = hold_q.data;
  assign bus.o_wstrb = hold_q.wr ? hold_q.be : 4'b0000;

  assign issue   = bus.o_req && bus.i_addr_ok;
  assign resp    = bus.i_data_ok && (cnt_q != '0);
  assign can_acc = !hold_v_q || issue;
  assign pop     = i_datareq_valid && can_acc;

  assign o_read_stall  = !can_acc;
  assign o_write_stall = !can_acc;
  assign o_rdata_valid = rdv_q;
  assign o_rdata       = rdata_q;
  assign o_idle        = !hold_v_q && (cnt_q == '0);

  always_comb begin
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    kind_d   = kind_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    rdv_d    = 1'b0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q + CW'(issue) - CW'(resp);
    if (pop) begin
      hold_v_d = 1'b1;
      hold_d   = '{va: i_va, data: i_data,
                   be: i_byteen, wr: i_wen & ~i_ren};
    end else if (issue) begin
      hold_v_d = 1'b0;
    end
    if (issue) begin
      kind_d[wptr_q] = hold_q.wr;
      wptr_d = (wptr_q == LASTP) ? '0 : wptr_q + PW'(1);
    end
    // Responses come back in issue order, so the queue head names this one.
    if (resp) begin
      rptr_d = (rptr_q == LASTP) ? '0 : rptr_q + PW'(1);
      if (!kind_q[rptr_q]) begin
        rdv_d   = 1'b1;
        rdata_d = bus.i_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
      cnt_q    <= '0;
      kind_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      rdv_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rdv_q    <= rdv_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule
